// File: rtl/unit_arbiter_pkg.sv
// unit_arbiter_pkg: shared request-select, control and data-word types for thread execution units
package unit_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0] ctrl_t;
  typedef enum logic [1:0] {
    UNIT_SEL_NONE = 2'd0,
    UNIT_SEL_ALU  = 2'd1,
    UNIT_SEL_MEM  = 2'd2
  } unit_sel_t;
  localparam ctrl_t ALU_CTRL_ADD = 4'd0;
  localparam ctrl_t ALU_CTRL_SUB = 4'd1;
  localparam ctrl_t ALU_CTRL_AND = 4'd2;
  localparam ctrl_t ALU_CTRL_OR  = 4'd3;
  localparam ctrl_t ALU_CTRL_XOR = 4'd4;
  localparam ctrl_t MEM_CTRL_READ  = 4'd0;
  localparam ctrl_t MEM_CTRL_WRITE = 4'd1;
endpackage

// File: rtl/unit_arbiter_rr_pick.sv
// rr_pick: round-robin selection of one requester, searching upward from ptr with wrap
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Descending scan so the requester closest to ptr is written last and wins
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin sharing of one combinational ALU and one handshaked memory port among threads
module unit_arbiter
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 2,
  parameter int IDX_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  unit_sel_t            thr_sel   [N_THREADS],
  input  ctrl_t                thr_ctrl  [N_THREADS],
  input  word_t                thr_in_a  [N_THREADS],
  input  word_t                thr_in_b  [N_THREADS],
  output word_t                thr_out   [N_THREADS],
  output logic [N_THREADS-1:0] thr_ready,
  output ctrl_t                alu_ctrl,
  output word_t                alu_a,
  output word_t                alu_b,
  input  word_t                alu_out,
  output logic                 mem_req,
  output ctrl_t                mem_ctrl,
  output word_t                mem_addr,
  output word_t                mem_wdata,
  input  logic                 mem_ack,
  input  word_t                mem_rdata
);
  typedef enum logic {IDLE, BUSY} mem_state_t;
  mem_state_t state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, alu_ptr_q, alu_ptr_d, mem_ptr_q, mem_ptr_d, alu_idx, mem_idx;
  ctrl_t mem_ctrl_q, mem_ctrl_d;
  word_t mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [N_THREADS-1:0] alu_reqs, mem_reqs;
  logic alu_valid, mem_valid, alu_grant, mem_done;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == N_THREADS - 1) ? '0 : i + 1'b1;
  endfunction

  // Split requests by unit; undefined selects fall into neither
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      alu_reqs[i] = thr_sel[i] == UNIT_SEL_ALU;
      mem_reqs[i] = thr_sel[i] == UNIT_SEL_MEM;
    end
  end

  rr_pick #(.N(N_THREADS), .W(IDX_W)) u_alu_pick (
    .req(alu_reqs), .ptr(alu_ptr_q), .valid(alu_valid), .idx(alu_idx)
  );

  rr_pick #(.N(N_THREADS), .W(IDX_W)) u_mem_pick (
    .req(mem_reqs), .ptr(mem_ptr_q), .valid(mem_valid), .idx(mem_idx)
  );

  assign alu_grant = alu_valid & ~rst;
  assign mem_done  = (state_q == BUSY) & mem_ack;

  // Next state: memory grant only from IDLE, release on ack; ALU pointer follows each grant
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_ptr_d   = mem_ptr_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_ptr_d   = alu_grant ? wrap_inc(alu_idx) : alu_ptr_q;
    if (state_q == IDLE && mem_valid) begin
      state_d     = BUSY;
      owner_d     = mem_idx;
      mem_ptr_d   = wrap_inc(mem_idx);
      mem_ctrl_d  = thr_ctrl[mem_idx];
      mem_addr_d  = thr_in_a[mem_idx];
      mem_wdata_d = thr_in_b[mem_idx];
    end else if (mem_done) begin
      state_d = IDLE;
    end
  end

  // Outputs: no-unit requests complete at once, ALU winner and memory owner on completion
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      thr_ready[i] = !alu_reqs[i] && !mem_reqs[i];
      thr_out[i]   = '0;
    end
    alu_ctrl = alu_grant ? thr_ctrl[alu_idx] : '0;
    alu_a    = alu_grant ? thr_in_a[alu_idx] : '0;
    alu_b    = alu_grant ? thr_in_b[alu_idx] : '0;
    if (alu_grant) begin
      thr_ready[alu_idx] = 1'b1;
      thr_out[alu_idx]   = alu_out;
    end
    if (mem_done) begin
      thr_ready[owner_q] = 1'b1;
      thr_out[owner_q]   = mem_rdata;
    end
  end

  assign mem_req   = state_q == BUSY;
  assign mem_ctrl  = mem_ctrl_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // State registers; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      alu_ptr_q   <= '0;
      mem_ptr_q   <= '0;
      mem_ctrl_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      alu_ptr_q   <= alu_ptr_d;
      mem_ptr_q   <= mem_ptr_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_unit_arbiter.sv
// tb_unit_arbiter: directed and randomized scoreboard bench for the unit arbiter
module tb_unit_arbiter;
  import unit_arbiter_pkg::*;
  localparam int N = 2;

  logic clk = 0, rst = 1;
  unit_sel_t thr_sel [N];
  ctrl_t thr_ctrl [N];
  word_t thr_in_a [N], thr_in_b [N], thr_out [N];
  logic [N-1:0] thr_ready;
  ctrl_t alu_ctrl, mem_ctrl;
  word_t alu_a, alu_b, alu_out, mem_addr, mem_wdata, mem_rdata;
  logic mem_req, mem_ack;

  int checks = 0, failures = 0;
  word_t exp_q [N][$];
  bit sb_on = 0, mem_auto = 1, force_ack = 0, ovr_en = 0;
  word_t ovr_data = '0;
  int mem_delay = 0;
  int last_alu = N - 1;

  always #5 clk = ~clk;

  unit_arbiter #(.N_THREADS(N)) dut (
    .clk(clk), .rst(rst),
    .thr_sel(thr_sel), .thr_ctrl(thr_ctrl), .thr_in_a(thr_in_a), .thr_in_b(thr_in_b),
    .thr_out(thr_out), .thr_ready(thr_ready),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .mem_req(mem_req), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic word_t alu_fn(ctrl_t c, word_t a, word_t b);
    case (c)
      ALU_CTRL_ADD: return a + b;
      ALU_CTRL_SUB: return a - b;
      ALU_CTRL_AND: return a & b;
      ALU_CTRL_OR:  return a | b;
      ALU_CTRL_XOR: return a ^ b;
      default:      return '0;
    endcase
  endfunction

  function automatic word_t mem_fn(word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign alu_out = alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic chk(string name, word_t got, word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic setq(int i, unit_sel_t s, ctrl_t c, word_t a, word_t b);
    thr_sel[i] = s;
    thr_ctrl[i] = c;
    thr_in_a[i] = a;
    thr_in_b[i] = b;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) setq(i, UNIT_SEL_NONE, '0, '0, '0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  // Memory responder: acks after mem_delay cycles of mem_req (random when negative)
  initial begin
    int cnt;
    bit in_txn;
    word_t t_addr;
    cnt = 0;
    in_txn = 0;
    t_addr = '0;
    mem_ack = 0;
    mem_rdata = '0;
    forever begin
      cyc();
      mem_ack = 0;
      if (!mem_auto) begin
        mem_ack = force_ack;
        in_txn = 0;
      end else if (!mem_req) begin
        in_txn = 0;
      end else begin
        if (!in_txn) begin
          in_txn = 1;
          t_addr = mem_addr;
          cnt = mem_delay < 0 ? int'($urandom_range(0, 4)) : mem_delay;
        end
        chk("mem_addr_stable", mem_addr, t_addr);
        if (cnt == 0) begin
          mem_ack = 1;
          mem_rdata = ovr_en ? ovr_data : mem_fn(mem_addr);
          in_txn = 0;
        end else cnt--;
      end
    end
  end

  // Scoreboard monitor: pops the expected result whenever a thread sees ready
  always @(negedge clk) begin
    if (sb_on) begin
      if (thr_sel[0] == UNIT_SEL_ALU && thr_sel[1] == UNIT_SEL_ALU)
        chk("rr_alu_grant", 32'(thr_ready), 32'(1 << ((last_alu + 1) % N)));
      for (int i = 0; i < N; i++) begin
        if (thr_ready[i]) begin
          if (exp_q[i].size() > 0) chk($sformatf("sb_out%0d", i), thr_out[i], exp_q[i].pop_front());
          else if (thr_sel[i] == UNIT_SEL_ALU || thr_sel[i] == UNIT_SEL_MEM) chk($sformatf("spurious_ready%0d", i), 32'd1, 32'd0);
          if (thr_sel[i] == UNIT_SEL_ALU) last_alu = i;
        end
      end
    end
  end

  task automatic drive(int i, int n);
    repeat (n) begin
      int s;
      bit ok;
      unit_sel_t sel;
      ctrl_t c;
      word_t a, b, e;
      s = $urandom_range(0, 9);
      sel = s < 4 ? UNIT_SEL_ALU : s < 7 ? UNIT_SEL_MEM : s < 9 ? UNIT_SEL_NONE : unit_sel_t'(2'd3);
      c = ctrl_t'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      e = sel == UNIT_SEL_ALU ? alu_fn(c, a, b) : sel == UNIT_SEL_MEM ? mem_fn(a) : '0;
      exp_q[i].push_back(e);
      setq(i, sel, c, a, b);
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = thr_ready[i];
      end
      if (!ok) chk($sformatf("timeout%0d", i), 32'd0, 32'd1);
      cyc();
    end
    setq(i, UNIT_SEL_NONE, '0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rq, rd, cy, c0_ack, c1_start;
    int order[$];
    word_t a, b;
    idle_all();
    setq(0, UNIT_SEL_ALU, ALU_CTRL_ADD, 1, 2);
    setq(1, UNIT_SEL_MEM, MEM_CTRL_READ, 4, 0);
    @(negedge clk);
    chk("rst_ready", 32'(thr_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    cyc();
    rst = 0;
    setq(1, UNIT_SEL_NONE, '0, '0, '0);
    setq(0, UNIT_SEL_ALU, ALU_CTRL_ADD, 5, 7);
    @(negedge clk);
    chk("t1_ready0", 32'(thr_ready[0]), 32'd1);
    chk("t1_out0", thr_out[0], 32'd12);
    chk("t1_ready_none", 32'(thr_ready[1]), 32'd1);
    chk("t1_out_none", thr_out[1], 32'd0);
    chk("t1_alu_a", alu_a, 32'd5);
    do_reset();

    setq(0, UNIT_SEL_ALU, ALU_CTRL_ADD, 1, 2);
    setq(1, UNIT_SEL_ALU, ALU_CTRL_SUB, 10, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_ready", 32'(thr_ready), k % 2 == 0 ? 32'd1 : 32'd2);
      chk("t2_out", k % 2 == 0 ? thr_out[0] : thr_out[1], k % 2 == 0 ? 32'd3 : 32'd7);
      cyc();
    end
    do_reset();

    mem_delay = 3;
    ovr_en = 1;
    ovr_data = 32'hDEADBEEF;
    setq(1, UNIT_SEL_MEM, MEM_CTRL_READ, 32'h100, 0);
    @(negedge clk);
    chk("t3_c0_req", 32'(mem_req), 32'd0);
    chk("t3_c0_ready", 32'(thr_ready[1]), 32'd0);
    rq = 0;
    rd = 0;
    for (int t = 0; t < 20 && rd == 0; t++) begin
      cyc();
      @(negedge clk);
      if (mem_req) begin
        rq++;
        chk("t3_addr", mem_addr, 32'h100);
      end
      if (thr_ready[1]) begin
        rd++;
        chk("t3_out", thr_out[1], 32'hDEADBEEF);
      end
    end
    chk("t3_req_cycles", 32'(rq), 32'd4);
    cyc();
    @(negedge clk);
    chk("t3_req_drop", 32'(mem_req), 32'd0);
    chk("t3_pulse", 32'(thr_ready[1]), 32'd0);
    ovr_en = 0;
    do_reset();

    mem_delay = 4;
    setq(0, UNIT_SEL_MEM, MEM_CTRL_READ, 32'h40, 0);
    rd = 0;
    for (int t = 0; t < 20 && rd == 0; t++) begin
      a = $urandom;
      b = $urandom;
      setq(1, UNIT_SEL_ALU, ALU_CTRL_XOR, a, b);
      @(negedge clk);
      chk("t4_alu_ready", 32'(thr_ready[1]), 32'd1);
      chk("t4_alu_out", thr_out[1], a ^ b);
      if (thr_ready[0]) begin
        rd = 1;
        chk("t4_mem_out", thr_out[0], mem_fn(32'h40));
      end
      cyc();
    end
    chk("t4_mem_done", 32'(rd), 32'd1);
    do_reset();

    mem_delay = 1;
    setq(0, UNIT_SEL_MEM, MEM_CTRL_READ, 32'h10, 0);
    setq(1, UNIT_SEL_MEM, MEM_CTRL_WRITE, 32'h20, 32'h55);
    c0_ack = -1;
    c1_start = -1;
    cy = 0;
    while (order.size() < 2 && cy < 30) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h20 && c1_start < 0) begin
        c1_start = cy;
        chk("t5_wdata", mem_wdata, 32'h55);
      end
      if (thr_ready[0] && thr_sel[0] == UNIT_SEL_MEM) begin
        order.push_back(0);
        c0_ack = cy;
        chk("t5_out0", thr_out[0], mem_fn(32'h10));
      end
      if (thr_ready[1] && thr_sel[1] == UNIT_SEL_MEM) begin
        order.push_back(1);
        chk("t5_out1", thr_out[1], mem_fn(32'h20));
      end
      cyc();
      if (thr_ready[0] === 1'b0 && c0_ack == cy) setq(0, UNIT_SEL_NONE, '0, '0, '0);
      if (c0_ack >= 0) setq(0, UNIT_SEL_NONE, '0, '0, '0);
      cy++;
    end
    chk("t5_count", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("t5_first", 32'(order[0]), 32'd0);
      chk("t5_second", 32'(order[1]), 32'd1);
    end
    chk("t5_gap", 32'(c1_start - c0_ack), 32'd2);
    do_reset();

    mem_delay = 0;
    mem_auto = 0;
    setq(0, UNIT_SEL_MEM, MEM_CTRL_READ, 32'h80, 0);
    cyc();
    cyc();
    @(negedge clk);
    chk("t6_busy", 32'(mem_req), 32'd1);
    #2 rst = 1;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_no_ready", 32'(thr_ready[0]), 32'd0);
    force_ack = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_stale_ack", 32'(thr_ready[0]), 32'd0);
    chk("t6_idle", 32'(mem_req), 32'd0);
    force_ack = 0;
    mem_auto = 1;
    cyc();
    @(negedge clk);
    chk("t6_req", 32'(mem_req), 32'd1);
    chk("t6_ready", 32'(thr_ready[0]), 32'd1);
    chk("t6_out", thr_out[0], mem_fn(32'h80));
    do_reset();

    last_alu = N - 1;
    mem_delay = -1;
    sb_on = 1;
    fork
      drive(0, 150);
      drive(1, 150);
    join
    repeat (3) cyc();
    sb_on = 0;
    for (int i = 0; i < N; i++) chk($sformatf("sb_drain%0d", i), 32'(exp_q[i].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
